wb_stage_lsu: RTL and testbench
===============================

Name: wb_stage_lsu

Overview:
Registered writeback stage for the pipelined RISC-V core, and the successor to the purely combinational writeback mux.
- Adds XLEN/register-address parametrisation.
- Formats sub-word loads (LB/LH/LW/LBU/LHU) with byte-lane selection and sign/zero extension.
- Supports variable-latency memory responses through a wait state with a backpressure handshake toward MEM.
- Sits between the MEM stage and the register file; its outputs drive the RF write port and the forwarding network.

Parameters:
XLEN, 32, datapath width (32 only for RV32; wider values zero-extend LW)
REG_ADDR_W, 5, register-file address width
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid_i  in  1  MEM stage presents an instruction
in_ready_o  out  1  stage can accept an instruction this cycle
rf_we_i  in  1  instruction writes the RF
rf_waddr_i  in  REG_ADDR_W  destination register
mem2rf_i  in  1  instruction is a load
mem_op_i  in  3  load funct3
mem_addr_lo_i  in  2  load address bits [1:0]
alu_result_i  in  XLEN  ALU result
mem_rvalid_i  in  1  load data valid
mem_rdata_i  in  XLEN  raw aligned memory word
rf_we_o  out  1  RF write enable (one-cycle pulse)
rf_waddr_o  out  REG_ADDR_W  RF write address
rf_wdata_o  out  XLEN  RF write data
stall_o  out  1  waiting for load data; upstream must hold
retired_o  out  CNT_W  count of completed instructions

Behaviour:
- FSM states: IDLE and WAIT_LOAD.
- in_ready_o = (state==IDLE); stall_o = (state==WAIT_LOAD). Both are combinational from state.
- Acceptance condition: in_valid_i && in_ready_o.
- Non-load accepted (mem2rf_i=0): next cycle rf_we_o = rf_we_i && (rf_waddr_i!=0), rf_waddr_o = rf_waddr_i, rf_wdata_o = alu_result_i. Latency 1.
- Load accepted with mem_rvalid_i=1 in the same cycle (zero-wait memory): formatted data appears next cycle, as for a non-load. State stays IDLE.
- Load accepted with mem_rvalid_i=0: latch rf_we, waddr, mem_op and addr_lo into holding registers, then go to WAIT_LOAD.
- In WAIT_LOAD, on mem_rvalid_i=1: formatted data registered to the outputs next cycle and state returns to IDLE. in_ready_o rises in the cycle after rvalid, so there is exactly one bubble.
- In WAIT_LOAD, in_valid_i is ignored; upstream holds the instruction.
- mem_rvalid_i while IDLE with no load being accepted: ignored, no output effect.
- Load formatting, with lane = addr_lo:
  - LB (000): sign-extend byte[lane].
  - LBU (100): zero-extend byte[lane].
  - LH (001): sign-extend half[addr_lo[1]]; addr_lo[0] ignored.
  - LHU (101): zero-extend half[addr_lo[1]]; addr_lo[0] ignored.
  - LW (010): full word, addr_lo ignored.
  - funct3 011/110/111: raw word passed through.
- rf_we_o is high for exactly one cycle per completed writing instruction. It is low on bubbles (no acceptance) and during WAIT_LOAD.
- Writes to x0 are suppressed: rf_we_o=0, but the instruction still retires.
- rf_waddr_o and rf_wdata_o hold their last values when rf_we_o=0.
- retired_o increments by 1 in the cycle rf_we_o would be produced, i.e. once per completed instruction, including rf_we_i=0 and x0 writes. Wraps modulo 2^CNT_W.
- Reset, in any state: state→IDLE; rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, retired_o=0, holding registers cleared.
  - A pending load is discarded.
  - An mem_rvalid_i arriving after reset is ignored.

Decomposition:
- Package rv_wb_pkg:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - wb_state_t enum {WB_IDLE, WB_WAIT_LOAD}.
- Sub-module wb_load_align: purely combinational; (mem_op, addr_lo, rdata) → formatted XLEN word. Reused by a future store-to-load forward path.

Test Plan:
- ALU op, rf_we=1, waddr=5, alu=0x0000_1234, in_valid=1 -> next cycle rf_we_o=1, waddr_o=5, wdata_o=0x0000_1234, retired_o 0→1.
- LB, addr_lo=2, rdata=0x1280_FF00, rvalid in the same cycle -> next cycle wdata_o=0xFFFF_FF80. With LBU instead -> 0x0000_0080.
- LH, addr_lo=2, rdata=0x8001_0000, rvalid 3 cycles late -> stall_o=1 and in_ready_o=0 for 3 cycles; cycle after rvalid: wdata_o=0xFFFF_8001, rf_we_o=1; in_ready_o=1 again that same cycle.
- ALU op to x0 with alu=0xDEAD_BEEF -> rf_we_o stays 0, retired_o still increments, wdata_o unchanged.
- Load waiting in WAIT_LOAD, rst=1 for one cycle, then rvalid=1 -> no rf_we_o pulse, state IDLE, retired_o=0.
- CNT_W=4, 17 back-to-back ALU ops -> retired_o wraps 15→0 and ends at 1; rf_we_o high every cycle.

Source files
------------

// File: rtl/wb_stage_lsu_pkg.sv
// rv_wb_pkg: shared load funct3 encodings and writeback FSM state type.
package rv_wb_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef enum logic {WB_IDLE, WB_WAIT_LOAD} wb_state_t;
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: selects the byte/half lane of a load word and sign/zero extends it.
module wb_load_align
    import rv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      mem_op_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign h = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    assign data_o = mem_op_i == F3_LB  ? {{(XLEN-8){b[7]}}, b} :
                    mem_op_i == F3_LBU ? {{(XLEN-8){1'b0}}, b} :
                    mem_op_i == F3_LH  ? {{(XLEN-16){h[15]}}, h} :
                    mem_op_i == F3_LHU ? {{(XLEN-16){1'b0}}, h} :
                    mem_op_i == F3_LW  ? XLEN'(rdata_i[31:0]) : rdata_i;
endmodule

// File: rtl/wb_stage_lsu.sv
// wb_stage_lsu: registered writeback stage with load formatting and a wait state
// for variable-latency memory responses.
module wb_stage_lsu
    import rv_wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  rf_we_i,
    input  logic [REG_ADDR_W-1:0] rf_waddr_i,
    input  logic                  mem2rf_i,
    input  logic [2:0]            mem_op_i,
    input  logic [1:0]            mem_addr_lo_i,
    input  logic [XLEN-1:0]       alu_result_i,
    input  logic                  mem_rvalid_i,
    input  logic [XLEN-1:0]       mem_rdata_i,
    output logic                  rf_we_o,
    output logic [REG_ADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]       rf_wdata_o,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      retired_o
);
    wb_state_t             state_q;
    logic                  hold_we_q;
    logic [REG_ADDR_W-1:0] hold_waddr_q;
    logic [2:0]            hold_op_q;
    logic [1:0]            hold_lo_q;
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_waddr_q;
    logic [XLEN-1:0]       rf_wdata_q;
    logic [CNT_W-1:0]      retired_q;
    logic                  accept, done, wr, we_sel;
    logic [REG_ADDR_W-1:0] waddr_sel;
    logic [2:0]            op_sel;
    logic [1:0]            lo_sel;
    logic [XLEN-1:0]       aligned, wdata_sel;

    assign stall_o    = state_q == WB_WAIT_LOAD;
    assign in_ready_o = state_q == WB_IDLE;
    assign accept     = in_valid_i && in_ready_o;
    assign done       = (accept && (!mem2rf_i || mem_rvalid_i)) || (stall_o && mem_rvalid_i);
    // While waiting, the instruction fields come from the holding registers.
    assign we_sel     = stall_o ? hold_we_q : rf_we_i;
    assign waddr_sel  = stall_o ? hold_waddr_q : rf_waddr_i;
    assign op_sel     = stall_o ? hold_op_q : mem_op_i;
    assign lo_sel     = stall_o ? hold_lo_q : mem_addr_lo_i;
    assign wdata_sel  = (stall_o || mem2rf_i) ? aligned : alu_result_i;
    assign wr         = done && we_sel && (waddr_sel != '0);

    wb_load_align #(.XLEN(XLEN)) u_align (
        .mem_op_i  (op_sel),
        .addr_lo_i (lo_sel),
        .rdata_i   (mem_rdata_i),
        .data_o    (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WB_IDLE;
            hold_we_q    <= 1'b0;
            hold_waddr_q <= '0;
            hold_op_q    <= '0;
            hold_lo_q    <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            retired_q    <= '0;
        end else begin
            rf_we_q <= wr;
            if (wr) begin
                rf_waddr_q <= waddr_sel;
                rf_wdata_q <= wdata_sel;
            end
            if (done)
                retired_q <= retired_q + CNT_W'(1);
            if (accept && mem2rf_i && !mem_rvalid_i) begin
                state_q      <= WB_WAIT_LOAD;
                hold_we_q    <= rf_we_i;
                hold_waddr_q <= rf_waddr_i;
                hold_op_q    <= mem_op_i;
                hold_lo_q    <= mem_addr_lo_i;
            end else if (stall_o && mem_rvalid_i) begin
                state_q <= WB_IDLE;
            end
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign retired_o  = retired_q;
endmodule

// File: tb/tb_wb_stage_lsu.sv
// tb_wb_stage_lsu: directed bench for the writeback stage, with a narrow-counter
// instance sharing the same stimulus to exercise counter wrap.
module tb_wb_stage_lsu;
    import rv_wb_pkg::*;
    logic        clk = 1'b0;
    logic        rst, in_valid, rf_we, mem2rf, rvalid;
    logic [4:0]  waddr;
    logic [2:0]  mem_op;
    logic [1:0]  addr_lo;
    logic [31:0] alu, rdata;
    logic        in_ready, we_o, stall, in_ready4, we_o4, stall4;
    logic [4:0]  waddr_o, waddr_o4;
    logic [31:0] wdata_o, wdata_o4;
    logic [31:0] retired;
    logic [3:0]  retired4;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    wb_stage_lsu dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .rf_we_i(rf_we), .rf_waddr_i(waddr), .mem2rf_i(mem2rf), .mem_op_i(mem_op),
        .mem_addr_lo_i(addr_lo), .alu_result_i(alu), .mem_rvalid_i(rvalid),
        .mem_rdata_i(rdata), .rf_we_o(we_o), .rf_waddr_o(waddr_o), .rf_wdata_o(wdata_o),
        .stall_o(stall), .retired_o(retired)
    );

    wb_stage_lsu #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready4),
        .rf_we_i(rf_we), .rf_waddr_i(waddr), .mem2rf_i(mem2rf), .mem_op_i(mem_op),
        .mem_addr_lo_i(addr_lo), .alu_result_i(alu), .mem_rvalid_i(rvalid),
        .mem_rdata_i(rdata), .rf_we_o(we_o4), .rf_waddr_o(waddr_o4), .rf_wdata_o(wdata_o4),
        .stall_o(stall4), .retired_o(retired4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; rf_we = 0; waddr = 0; mem2rf = 0; mem_op = 0;
        addr_lo = 0; alu = 0; rvalid = 0; rdata = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
        tests++; if (we_o !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", we_o); end
        tests++; if (waddr_o !== 5'd0) begin fails++; $display("FAIL reset_waddr got %0d want 0", waddr_o); end
        tests++; if (wdata_o !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h want 0", wdata_o); end
        tests++; if (retired !== 32'd0) begin fails++; $display("FAIL reset_retired got %0d want 0", retired); end
        tests++; if (in_ready !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL reset_state ready %b stall %b want 1 0", in_ready, stall); end
    endtask

    task automatic test_alu();
        in_valid = 1; rf_we = 1; waddr = 5; alu = 32'h0000_1234;
        step();
        idle();
        tests++; if (we_o !== 1'b1) begin fails++; $display("FAIL alu_we got %b want 1", we_o); end
        tests++; if (waddr_o !== 5'd5) begin fails++; $display("FAIL alu_waddr got %0d want 5", waddr_o); end
        tests++; if (wdata_o !== 32'h0000_1234) begin fails++; $display("FAIL alu_wdata got %h want 00001234", wdata_o); end
        tests++; if (retired !== 32'd1) begin fails++; $display("FAIL alu_retired got %0d want 1", retired); end
        step();
        tests++; if (we_o !== 1'b0) begin fails++; $display("FAIL alu_pulse got %b want 0", we_o); end
        tests++; if (wdata_o !== 32'h0000_1234) begin fails++; $display("FAIL alu_hold got %h want 00001234", wdata_o); end
    endtask

    task automatic test_load_zero_wait();
        in_valid = 1; rf_we = 1; waddr = 6; mem2rf = 1; mem_op = F3_LB; addr_lo = 2;
        rvalid = 1; rdata = 32'h1280_FF00; alu = 32'h5555_5555;
        step();
        tests++; if (we_o !== 1'b1 || wdata_o !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb got we %b data %h want 1 ffffff80", we_o, wdata_o); end
        mem_op = F3_LBU;
        step();
        idle();
        tests++; if (we_o !== 1'b1 || wdata_o !== 32'h0000_0080) begin fails++; $display("FAIL lbu got we %b data %h want 1 00000080", we_o, wdata_o); end
        tests++; if (retired !== 32'd3) begin fails++; $display("FAIL lb_retired got %0d want 3", retired); end
    endtask

    task automatic test_load_wait();
        in_valid = 1; rf_we = 1; waddr = 7; mem2rf = 1; mem_op = F3_LH; addr_lo = 2; rvalid = 0;
        step();
        // A different instruction is offered while waiting; it must be ignored.
        mem2rf = 0; mem_op = F3_LBU; addr_lo = 0; waddr = 9; alu = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            tests++; if (stall !== 1'b1 || in_ready !== 1'b0 || we_o !== 1'b0) begin fails++; $display("FAIL wait_%0d stall %b ready %b we %b want 1 0 0", i, stall, in_ready, we_o); end
            if (i < 2) step();
        end
        rvalid = 1; rdata = 32'h8001_0000;
        step();
        in_valid = 0; rvalid = 0;
        tests++; if (we_o !== 1'b1 || waddr_o !== 5'd7 || wdata_o !== 32'hFFFF_8001) begin fails++; $display("FAIL lh_late got we %b addr %0d data %h want 1 7 ffff8001", we_o, waddr_o, wdata_o); end
        tests++; if (in_ready !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL lh_ready got ready %b stall %b want 1 0", in_ready, stall); end
        tests++; if (retired !== 32'd4) begin fails++; $display("FAIL lh_retired got %0d want 4", retired); end
        idle();
        step();
    endtask

    task automatic test_x0();
        in_valid = 1; rf_we = 1; waddr = 0; alu = 32'hDEAD_BEEF;
        step();
        idle();
        tests++; if (we_o !== 1'b0) begin fails++; $display("FAIL x0_we got %b want 0", we_o); end
        tests++; if (wdata_o !== 32'hFFFF_8001 || waddr_o !== 5'd7) begin fails++; $display("FAIL x0_hold got addr %0d data %h want 7 ffff8001", waddr_o, wdata_o); end
        tests++; if (retired !== 32'd5) begin fails++; $display("FAIL x0_retired got %0d want 5", retired); end
        rvalid = 1; rdata = 32'hAAAA_AAAA;
        step();
        idle();
        tests++; if (we_o !== 1'b0 || retired !== 32'd5) begin fails++; $display("FAIL stray_rvalid got we %b retired %0d want 0 5", we_o, retired); end
    endtask

    task automatic test_reset_pending();
        in_valid = 1; rf_we = 1; waddr = 3; mem2rf = 1; mem_op = F3_LW; rvalid = 0;
        step();
        idle();
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL pend_stall got %b want 1", stall); end
        rst = 1;
        step();
        rst = 0; rvalid = 1; rdata = 32'h7777_7777;
        step();
        idle();
        tests++; if (we_o !== 1'b0 || stall !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL pend_discard we %b stall %b ready %b want 0 0 1", we_o, stall, in_ready); end
        tests++; if (retired !== 32'd0) begin fails++; $display("FAIL pend_retired got %0d want 0", retired); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1; rf_we = 1; waddr = 1;
        for (int i = 0; i < 17; i++) begin
            alu = 32'(i);
            step();
            tests++; if (we_o !== 1'b1 || wdata_o !== 32'(i)) begin fails++; $display("FAIL b2b_%0d we %b data %h want 1 %h", i, we_o, wdata_o, 32'(i)); end
            tests++; if (retired4 !== 4'((i + 1) % 16)) begin fails++; $display("FAIL wrap_%0d got %0d want %0d", i, retired4, (i + 1) % 16); end
        end
        idle();
        tests++; if (retired4 !== 4'd1 || retired !== 32'd17) begin fails++; $display("FAIL wrap_end got %0d %0d want 1 17", retired4, retired); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_zero_wait();
        test_load_wait();
        test_x0();
        test_reset_pending();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
